// File: rtl/regwb_pkg.sv
// regwb_pkg: shared state encoding, register-file geometry and widths for the writeback arbiter.
package regwb_pkg;
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam int DATA_W = 32;
    localparam int REG_W = 5;
    localparam int NREGS = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_LAST = 5'd31;
endpackage

// File: rtl/regwb_age.sv
// regwb_age: saturating count of consecutive cycles requester A was denied while valid.
module regwb_age #(
    parameter int STARVE_MAX = 4,
    parameter int AGE_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic starved
);
    logic [AGE_W-1:0] age;
    assign starved = age == AGE_W'(STARVE_MAX);
    always_ff @(posedge clk) begin
        if (rst || clr) age <= '0;
        else if (inc && !starved) age <= age + 1'b1;
    end
endmodule

// File: rtl/regwb_arbiter.sv
// regwb_arbiter: register-file write-port arbiter, B priority with A starvation guard, $0 writes dropped.
// REGWB_CLEAR_EN compiles in a post-reset sweep that zeroes registers 1..31 before any grant.
module regwb_arbiter
    import regwb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AGE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_W-1:0]  b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              we,
    output logic [REG_W-1:0]  wreg,
    output logic [DATA_W-1:0] wdata,
    output logic              busy
);
    logic run, starved, grant_a, grant_b;
    logic [REG_W-1:0] sweep_reg;
`ifdef REGWB_CLEAR_EN
    state_t state, state_nx;
    logic [REG_W-1:0] idx;
    always_ff @(posedge clk) state <= rst ? ST_CLEAR : state_nx;
    always_comb state_nx = (state == ST_CLEAR && idx == REG_LAST) ? ST_RUN : state;
    always_ff @(posedge clk) idx <= rst ? REG_W'(1) : (run ? idx : idx + 1'b1);
    assign run = state == ST_RUN;
    assign sweep_reg = idx;
`else
    assign run = 1'b1;
    assign sweep_reg = REG_ZERO;
`endif
    always_comb begin
        grant_b = run && !rst && b_valid && !(a_valid && starved);
        grant_a = run && !rst && a_valid && !grant_b;
    end
    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign busy = !run;
    regwb_age #(.STARVE_MAX(STARVE_MAX), .AGE_W(AGE_W)) u_age (
        .clk(clk),
        .rst(rst),
        .inc(run && a_valid && !grant_a),
        .clr(run && (grant_a || !a_valid)),
        .starved(starved)
    );
    // A grant to $0 still loads wreg/wdata; only the enable is suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            we <= 1'b0;
            wreg <= REG_ZERO;
            wdata <= '0;
        end else if (!run) begin
            we <= 1'b1;
            wreg <= sweep_reg;
            wdata <= '0;
        end else if (grant_b) begin
            we <= b_reg != REG_ZERO;
            wreg <= b_reg;
            wdata <= b_data;
        end else if (grant_a) begin
            we <= a_reg != REG_ZERO;
            wreg <= a_reg;
            wdata <= a_data;
        end else begin
            we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regwb_arbiter.sv
// tb_regwb_arbiter: scoreboard bench; expected commits are queued at handshake time and checked a cycle later.
module tb_regwb_arbiter;
    localparam int SMAX = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0] a_reg = '0, b_reg = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic a_ready, b_ready, we, busy;
    logic [4:0] wreg;
    logic [31:0] wdata;
    int checks = 0, failures = 0;
    int m_age = 0;
    logic [4:0] m_wreg = '0;
    logic [31:0] m_wdata = '0;
    logic [37:0] sb[$];

    regwb_arbiter #(.STARVE_MAX(SMAX), .AGE_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .we(we), .wreg(wreg), .wdata(wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One RUN cycle: called at posedge+1, checks readies at the falling edge and the commit after the next rise.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd);
        logic ga, gb, ewe;
        logic [37:0] e;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        #4;
        gb = bv && !(av && m_age == SMAX);
        ga = av && !gb;
        check("b_ready", 32'(b_ready), 32'(gb));
        check("a_ready", 32'(a_ready), 32'(ga));
        check("busy_run", 32'(busy), 32'd0);
        ewe = 1'b0;
        if (gb) begin ewe = br != 0; m_wreg = br; m_wdata = bd; end
        else if (ga) begin ewe = ar != 0; m_wreg = ar; m_wdata = ad; end
        sb.push_back({ewe, m_wreg, m_wdata});
        m_age = (av && !ga) ? (m_age < SMAX ? m_age + 1 : m_age) : 0;
        @(posedge clk); #1;
        if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else begin
            e = sb.pop_front();
            check("we", 32'(we), 32'(e[37]));
            check("wreg", 32'(wreg), 32'(e[36:32]));
            check("wdata", wdata, e[31:0]);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_reg = 5'd3; b_reg = 5'd4;
        for (int i = 0; i < n; i++) begin
            #4;
            check("rst_a_ready", 32'(a_ready), 32'd0);
            check("rst_b_ready", 32'(b_ready), 32'd0);
            @(posedge clk); #1;
            check("rst_we", 32'(we), 32'd0);
            check("rst_wreg", 32'(wreg), 32'd0);
            check("rst_wdata", wdata, 32'd0);
`ifdef REGWB_CLEAR_EN
            check("rst_busy", 32'(busy), 32'd1);
`else
            check("rst_busy", 32'(busy), 32'd0);
`endif
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        m_age = 0; m_wreg = '0; m_wdata = '0;
    endtask

`ifdef REGWB_CLEAR_EN
    task automatic sweep(input int n);
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 1; i <= n; i++) begin
            #4;
            check("clr_busy", 32'(busy), 32'd1);
            check("clr_ready", 32'({a_ready, b_ready}), 32'd0);
            @(posedge clk); #1;
            check("clr_we", 32'(we), 32'd1);
            check("clr_wreg", 32'(wreg), 32'(i));
            check("clr_wdata", wdata, 32'd0);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        m_wreg = 5'd31; m_wdata = '0;
    endtask
`endif

    initial begin
        @(posedge clk); #1;
        do_reset(2);
`ifdef REGWB_CLEAR_EN
        sweep(9);
        do_reset(1);
        sweep(31);
`endif
        step(1, 5'd8, 32'h0000_1234, 0, 5'd0, 32'h0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        for (int i = 0; i < 11; i++) step(1, 5'd3, 32'(i), 1, 5'd4, 32'(100 + i));
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF);
        step(1, 5'd9, 32'd7, 1, 5'd9, 32'd5);
        step(1, 5'd9, 32'd7, 0, 5'd0, 32'h0);
        step(1, 5'd0, 32'hDEAD_BEEF, 0, 5'd0, 32'h0);
        for (int i = 0; i < 24; i++)
            step(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
        for (int i = 0; i < 3; i++) step(1, 5'd6, 32'(i), 1, 5'd7, 32'(i));
        do_reset(1);
`ifdef REGWB_CLEAR_EN
        sweep(31);
`endif
        for (int i = 0; i < 6; i++) step(1, 5'd10, 32'(i), 1, 5'd11, 32'(i));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
